// File: rtl/dp_sequencer.sv
// Multi-cycle sequencer for ARM data-processing instructions: decode, operand
// fetch and barrel shift, condition check, ALU wait, write-back and flag update.
module dp_sequencer #(
  parameter int ALU_LAT = 1
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        START,
  input  logic [31:0] INSTR,
  output logic        BUSY,
  output logic        DONE,
  output logic        SKIPPED,
  output logic        ILLEGAL,
  output logic [3:0]  RF_RA,
  output logic [3:0]  RF_RB,
  input  logic [31:0] RF_DA,
  input  logic [31:0] RF_DB,
  output logic        RF_WE,
  output logic [3:0]  RF_WA,
  output logic [31:0] RF_WD,
  output logic [3:0]  ALU_FN,
  output logic [31:0] ALU_LEFT,
  output logic [31:0] ALU_RIGHT,
  output logic        ALU_CIN,
  input  logic [31:0] ALU_RESULT,
  input  logic        ALU_N,
  input  logic        ALU_Z,
  input  logic        ALU_C,
  input  logic        ALU_V,
  output logic [3:0]  FLAGS
);

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_WB, S_SKIP} state_t;

  state_t      state_q, state_d;
  logic [31:0] instr_q;
  logic [3:0]  exec_cnt;
  logic [3:0]  fn_q;
  logic [31:0] left_q, right_q;
  logic        cin_q, sc_q, ill_q;
  logic [3:0]  flags_q;

  logic        bad_form, cond_pass;
  logic [3:0]  opc;
  logic        is_sub, is_add, is_test;
  logic [31:0] sh_res;
  logic        sh_c;
  logic [63:0] wide;
  logic [4:0]  rot, amt;
  logic [31:0] imm32;
  logic        fn, fz, fc, fv;

  assign bad_form = (INSTR[27:26] != 2'b00) || (!INSTR[25] && INSTR[4]);
  assign opc      = instr_q[24:21];
  assign is_sub   = opc inside {4'b0010, 4'b0011, 4'b0110, 4'b0111, 4'b1010};
  assign is_add   = opc inside {4'b0100, 4'b0101, 4'b1011};
  assign is_test  = (opc[3:2] == 2'b10);
  assign {fn, fz, fc, fv} = flags_q;

  // Condition field evaluated against the flags as they stand in DECODE
  always_comb begin
    cond_pass = 1'b0;
    unique case (instr_q[31:28])
      4'h0: cond_pass = fz;
      4'h1: cond_pass = !fz;
      4'h2: cond_pass = fc;
      4'h3: cond_pass = !fc;
      4'h4: cond_pass = fn;
      4'h5: cond_pass = !fn;
      4'h6: cond_pass = fv;
      4'h7: cond_pass = !fv;
      4'h8: cond_pass = fc && !fz;
      4'h9: cond_pass = !fc || fz;
      4'hA: cond_pass = (fn == fv);
      4'hB: cond_pass = (fn != fv);
      4'hC: cond_pass = !fz && (fn == fv);
      4'hD: cond_pass = fz || (fn != fv);
      4'hE: cond_pass = 1'b1;
      4'hF: cond_pass = 1'b0;
    endcase
  end

  // Barrel shifter; a zero register-shift amount encodes the 32-bit / RRX forms
  always_comb begin
    sh_res = RF_DB;
    sh_c   = fc;
    wide   = '0;
    rot    = {instr_q[11:8], 1'b0};
    amt    = instr_q[11:7];
    imm32  = {24'b0, instr_q[7:0]};
    if (instr_q[25]) begin
      sh_res = (imm32 >> rot) | (imm32 << (6'd32 - {1'b0, rot}));
      sh_c   = (rot == 5'd0) ? fc : sh_res[31];
    end else begin
      unique case (instr_q[6:5])
        2'b00: begin
          if (amt != 5'd0) begin
            wide   = {32'b0, RF_DB} << amt;
            sh_res = wide[31:0];
            sh_c   = wide[32];
          end
        end
        2'b01: begin
          if (amt == 5'd0) begin
            sh_res = '0;
            sh_c   = RF_DB[31];
          end else begin
            wide   = {RF_DB, 32'b0} >> amt;
            sh_res = wide[63:32];
            sh_c   = wide[31];
          end
        end
        2'b10: begin
          if (amt == 5'd0) begin
            sh_res = {32{RF_DB[31]}};
            sh_c   = RF_DB[31];
          end else begin
            wide   = 64'($signed({RF_DB, 32'b0}) >>> amt);
            sh_res = wide[63:32];
            sh_c   = wide[31];
          end
        end
        2'b11: begin
          if (amt == 5'd0) begin
            sh_res = {fc, RF_DB[31:1]};
            sh_c   = RF_DB[0];
          end else begin
            wide   = {RF_DB, RF_DB} >> amt;
            sh_res = wide[31:0];
            sh_c   = sh_res[31];
          end
        end
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (START && !bad_form) state_d = S_DECODE;
      S_DECODE: state_d = cond_pass ? S_EXEC : S_SKIP;
      S_EXEC:   if (exec_cnt == 4'(ALU_LAT - 1)) state_d = S_WB;
      S_WB:     state_d = S_IDLE;
      S_SKIP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      instr_q  <= '0;
      exec_cnt <= '0;
      fn_q     <= '0;
      left_q   <= '0;
      right_q  <= '0;
      cin_q    <= 1'b0;
      sc_q     <= 1'b0;
      ill_q    <= 1'b0;
      flags_q  <= '0;
    end else begin
      ill_q <= (state_q == S_IDLE) && START && bad_form;
      if (state_q == S_IDLE && START && !bad_form) instr_q <= INSTR;
      if (state_q == S_DECODE) begin
        exec_cnt <= '0;
        fn_q     <= opc;
        left_q   <= RF_DA;
        right_q  <= sh_res;
        sc_q     <= sh_c;
        cin_q    <= fc;
      end
      if (state_q == S_EXEC) exec_cnt <= exec_cnt + 4'd1;
      // ALU reports borrow on subtracts; ARM C is its inverse
      if (state_q == S_WB && (instr_q[20] || is_test)) begin
        if (is_sub)      flags_q <= {ALU_N, ALU_Z, ~ALU_C, ALU_V};
        else if (is_add) flags_q <= {ALU_N, ALU_Z, ALU_C, ALU_V};
        else             flags_q <= {ALU_N, ALU_Z, sc_q, fv};
      end
    end
  end

  assign BUSY      = (state_q != S_IDLE);
  assign DONE      = (state_q == S_WB) || (state_q == S_SKIP);
  assign SKIPPED   = (state_q == S_SKIP);
  assign ILLEGAL   = ill_q;
  assign RF_RA     = (state_q == S_DECODE) ? instr_q[19:16] : 4'd0;
  assign RF_RB     = (state_q == S_DECODE) ? instr_q[3:0] : 4'd0;
  assign RF_WE     = (state_q == S_WB) && !is_test;
  assign RF_WA     = (state_q == S_WB) ? instr_q[15:12] : 4'd0;
  assign RF_WD     = (state_q == S_WB) ? ALU_RESULT : 32'd0;
  assign ALU_FN    = fn_q;
  assign ALU_LEFT  = left_q;
  assign ALU_RIGHT = right_q;
  assign ALU_CIN   = cin_q;
  assign FLAGS     = flags_q;

endmodule

// File: doc/dp_sequencer.md
DP_SEQUENCER -- requirements
Module: dp_sequencer

Interface
REQ-001 Parameter ALU_LAT, default 1, meaning the number of clock cycles the ALU result is allowed to settle (range 1..15).
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  CLK  in  1  single clock, rising edge.
  RESET_N  in  1  asynchronous, active-low reset.
  START  in  1  request to execute INSTR; sampled only in IDLE.
  INSTR  in  32  ARM data-processing instruction word.
  BUSY  out  1  high whenever state != IDLE.
  DONE  out  1  one-cycle pulse at instruction completion (executed or skipped).
  SKIPPED  out  1  valid with DONE; condition failed.
  ILLEGAL  out  1  one-cycle pulse; INSTR is not a supported data-processing form.
  RF_RA, RF_RB  out  4  register-file read addresses (Rn, Rm).
  RF_DA, RF_DB  in  32  combinational read data for RF_RA and RF_RB.
  RF_WE  out  1  register write enable.
  RF_WA  out  4  write address (Rd).
  RF_WD  out  32  write data.
  ALU_FN  out  4  ALU opcode (INSTR[24:21]).
  ALU_LEFT, ALU_RIGHT  out  32  Rn value and shifter operand.
  ALU_CIN  out  1  current C flag.
  ALU_RESULT  in  32  ALU output.
  ALU_N, ALU_Z, ALU_C, ALU_V  in  1  ALU flags.
  FLAGS  out  4  architectural {N,Z,C,V}.

Function
REQ-003 States SHALL be IDLE, DECODE, EXEC, WB, SKIP.
REQ-004 IDLE with START=1: if INSTR[27:26]!=00, or INSTR[25]=0 with INSTR[4]=1 (register-specified shift), pulse ILLEGAL for 1 cycle and stay in IDLE; otherwise latch INSTR and go to DECODE.
REQ-005 START outside IDLE SHALL be ignored, and INSTR SHALL NOT be re-sampled.
REQ-006 DECODE: drive RF_RA=INSTR[19:16] and RF_RB=INSTR[3:0]; on the clock edge, register ALU_LEFT=RF_DA, register ALU_RIGHT and the shifter carry (SC), then evaluate the condition INSTR[31:28] against FLAGS.
REQ-007 Condition codes: EQ..LE per ARM; AL (1110) passes; 1111 never passes. Fail -> SKIP; pass -> EXEC.
REQ-008 Immediate shifter (I=1): imm8 rotated right by 2*INSTR[11:8]; SC=C if rotate is 0, else result[31].
REQ-009 Register shifter (I=0), amount=INSTR[11:7], type=INSTR[6:5]:
  LSL #0 -> Rm, SC=C.
  LSR #0 -> 0, SC=Rm[31].
  ASR #0 -> all bits Rm[31], SC=Rm[31].
  ROR #0 -> RRX {C,Rm[31:1]}, SC=Rm[0].
  Nonzero amounts: standard shift; SC = last bit shifted out.
REQ-010 EXEC SHALL last exactly ALU_LAT cycles, then go to WB; ALU_FN, ALU_LEFT, ALU_RIGHT and ALU_CIN SHALL stay constant from EXEC entry through WB.
REQ-011 WB (one cycle): DONE=1, SKIPPED=0. RF_WE=1, RF_WA=INSTR[15:12], RF_WD=ALU_RESULT, except for opcodes 1000-1011, which force RF_WE=0.
REQ-012 Flag update SHALL occur on the edge leaving WB, when S=1 or opcode is 10xx.
REQ-013 Flag rule, arithmetic (SUB, RSB, SBC, RSC, CMP): N,Z,V from the ALU; C = ~ALU_C (ALU reports borrow).
REQ-014 Flag rule, arithmetic (ADD, ADC, CMN): N,Z,C,V from the ALU.
REQ-015 Flag rule, logical ops: N,Z from the ALU; C=SC; V unchanged.
REQ-016 SKIP (one cycle): DONE=1, SKIPPED=1, RF_WE=0, FLAGS unchanged; then IDLE.
REQ-017 WB SHALL return to IDLE. Latency: START edge to DONE = ALU_LAT+2 cycles; skipped instructions take 2 cycles.
REQ-018 RF_WE SHALL be 0 in every state except WB; ILLEGAL and DONE SHALL never be high together.

Reset
REQ-019 RESET_N=0 SHALL immediately force IDLE, FLAGS=0000, and all outputs to 0, including mid-instruction; an aborted instruction SHALL produce no write and no flag change.
REQ-020 After RESET_N rises, the first START SHALL be honoured on the first rising edge.

Verification
REQ-021 R1=5, R2=7, INSTR=0xE0913002 (ADDS R3,R1,R2), ALU_LAT=1 -> DONE 3 cycles after START; RF_WE pulse with WA=3, WD=12; FLAGS=0000.
REQ-022 R1=5, INSTR=0xE1510001 (CMP R1,R1) -> RF_WE never asserted; FLAGS N=0, Z=1, C=1, V=0.
REQ-023 INSTR=0xE3B044FF (MOVS R4,#0xFF000000) -> WD=0xFF000000; N=1, Z=0, C=1; V unchanged.
REQ-024 FLAGS Z=0, INSTR=0x00813002 (ADDEQ) -> DONE and SKIPPED pulse 2 cycles after START; no RF_WE; FLAGS unchanged.
REQ-025 INSTR=0xEA000000 -> ILLEGAL for 1 cycle; BUSY stays 0.
REQ-026 RESET_N dropped during EXEC of ADDS -> no RF_WE, FLAGS=0000, BUSY=0; the next START executes normally.
